// File: rtl/data_ram_sized_if.sv
// Bus bundle for data_ram_sized: a single-cycle sized load/store port plus status flags.
// The master drives the access; the slave returns registered load data and flags.
interface data_ram_sized_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  sel;
    logic                  we;
    logic [ADDR_WIDTH+1:0] addr;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [31:0]           d;
    logic [31:0]           q;
    logic                  misalign;
    logic                  busy;

    modport master (
        output sel, we, addr, size, sign_ext, d,
        input  q, misalign, busy
    );

    modport slave (
        input  sel, we, addr, size, sign_ext, d,
        output q, misalign, busy
    );
endinterface

// File: rtl/data_ram_sized.sv
// Byte-addressed 32-bit data RAM with byte/half/word loads and stores, sign/zero extension,
// misalignment detection and an optional zero-fill sequence after reset.
module data_ram_sized #(
    parameter int ADDR_WIDTH = 10,
    parameter bit INIT_CLEAR = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    data_ram_sized_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam state_t RESET_STATE = INIT_CLEAR ? CLEAR : READY;

    logic [31:0]           mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]           q_q, q_d;
    logic                  misalign_q, misalign_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_widx;
    logic [31:0]           mem_wdata;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            offset;
    logic                  bad_align;
    logic [3:0]            lane_mask;
    logic [31:0]           wdata_rep;
    logic [31:0]           merged;
    logic [31:0]           shifted;
    logic [31:0]           formatted;

    assign word_idx = bus.addr[ADDR_WIDTH+1:2];
    assign offset   = bus.addr[1:0];

    // Decode the access: alignment, affected lanes, replicated store data, and the
    // post-write word formatted for the load path (write-first).
    always_comb begin
        bad_align = 1'b0;
        lane_mask = 4'b1111;
        wdata_rep = bus.d;
        case (bus.size)
            2'b00: begin
                lane_mask = 4'b0001 << offset;
                wdata_rep = {4{bus.d[7:0]}};
            end
            2'b01: begin
                bad_align = offset[0];
                lane_mask = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.d[15:0]}};
            end
            2'b10:   bad_align = (offset != 2'b00);
            default: bad_align = 1'b1;
        endcase

        merged = mem[word_idx];
        if (bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    merged[8*i +: 8] = wdata_rep[8*i +: 8];
                end
            end
        end

        // Aligned halves have offset[0]=0, so one byte-granular shift serves all sizes.
        shifted = merged >> {offset, 3'b000};
        case (bus.size)
            2'b00:   formatted = {{24{bus.sign_ext & shifted[7]}}, shifted[7:0]};
            2'b01:   formatted = {{16{bus.sign_ext & shifted[15]}}, shifted[15:0]};
            default: formatted = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        q_d        = q_q;
        misalign_d = 1'b0;
        mem_we     = 1'b0;
        mem_widx   = word_idx;
        mem_wdata  = merged;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_cnt_q;
                mem_wdata = 32'h0000_0000;
                q_d       = 32'h0000_0000;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    clr_cnt_d = '0;
                    state_d   = READY;
                end
            end
            default: begin
                if (bus.sel) begin
                    if (bad_align) begin
                        q_d        = 32'h0000_0000;
                        misalign_d = 1'b1;
                    end else begin
                        q_d    = formatted;
                        mem_we = bus.we;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            clr_cnt_q  <= '0;
            q_q        <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            q_q        <= q_d;
            misalign_q <= misalign_d;
        end
    end

    // The array has no reset; only the clear sequence zero-fills it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign bus.q        = q_q;
    assign bus.misalign = misalign_q;
    assign bus.busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_data_ram_sized.sv
// Directed, table-driven bench for data_ram_sized (ADDR_WIDTH=4) with hand sequences for
// the clear, asynchronous reset and reset-mid-clear cases.
module tb_data_ram_sized;
    localparam int AW = 4;

    typedef struct {
        logic        sel;
        logic        we;
        logic [5:0]  addr;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] d;
        logic [31:0] exp_q;
        logic        exp_mis;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cycles;
    vec_t vecs[$];

    data_ram_sized_if #(.ADDR_WIDTH(AW)) bus ();

    data_ram_sized #(
        .ADDR_WIDTH (AW),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sel, input logic we, input logic [5:0] addr,
                       input logic [1:0] size, input logic sx, input logic [31:0] d,
                       input logic [31:0] eq, input logic em);
        vec_t v;
        v.sel = sel; v.we = we; v.addr = addr; v.size = size; v.sign_ext = sx;
        v.d = d; v.exp_q = eq; v.exp_mis = em;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic sel, input logic we, input logic [5:0] addr,
                         input logic [1:0] size, input logic sx, input logic [31:0] d);
        bus.sel = sel; bus.we = we; bus.addr = addr; bus.size = size;
        bus.sign_ext = sx; bus.d = d;
    endtask

    // Counts rising edges while busy is high; accesses during the clear must stay invisible.
    task automatic count_clear(input string name);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            check({name, " q in clear"}, bus.q, 32'h0);
            check({name, " misalign in clear"}, {31'b0, bus.misalign}, 32'h0);
            cycles++;
        end
        check({name, " busy cycles"}, cycles, 16);
    endtask

    task automatic read_word(input string name, input logic [5:0] addr, input logic [31:0] exp);
        @(negedge clk);
        drive(1'b1, 1'b0, addr, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check(name, bus.q, exp);
        @(negedge clk);
        drive(1'b0, 1'b0, 6'h0, 2'b10, 1'b0, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        add(1,1,6'h00,2'b10,0,32'h11223344,32'h11223344,0);
        add(1,1,6'h02,2'b00,0,32'h000000AA,32'h000000AA,0);
        add(1,0,6'h00,2'b10,0,32'h0,       32'h11AA3344,0);
        add(1,1,6'h00,2'b01,0,32'h0000BEEF,32'h0000BEEF,0);
        add(1,0,6'h00,2'b10,0,32'h0,       32'h11AABEEF,0);
        add(1,1,6'h04,2'b10,0,32'h0080FF7F,32'h0080FF7F,0);
        add(1,0,6'h05,2'b00,1,32'h0,       32'hFFFFFFFF,0);
        add(1,0,6'h04,2'b00,0,32'h0,       32'h0000007F,0);
        add(1,0,6'h06,2'b01,1,32'h0,       32'h00000080,0);
        add(1,0,6'h04,2'b01,1,32'h0,       32'hFFFFFF7F,0);
        add(1,0,6'h04,2'b01,0,32'h0,       32'h0000FF7F,0);
        add(1,1,6'h08,2'b10,0,32'hCAFEF00D,32'hCAFEF00D,0);
        add(1,1,6'h09,2'b10,0,32'hDEADBEEF,32'h00000000,1);
        add(1,0,6'h08,2'b10,0,32'h0,       32'hCAFEF00D,0);
        add(1,1,6'h08,2'b11,0,32'h55555555,32'h00000000,1);
        add(1,0,6'h08,2'b10,0,32'h0,       32'hCAFEF00D,0);
        add(0,1,6'h08,2'b10,0,32'h0,       32'hCAFEF00D,0);
        add(1,1,6'h0B,2'b01,0,32'h00001234,32'h00000000,1);
        add(0,0,6'h00,2'b10,0,32'h0,       32'h00000000,0);
        add(1,0,6'h08,2'b10,0,32'h0,       32'hCAFEF00D,0);
        add(1,1,6'h0C,2'b10,0,32'h12345678,32'h12345678,0);
        add(1,0,6'h0C,2'b10,0,32'h0,       32'h12345678,0);
        add(1,1,6'h3C,2'b10,0,32'hA5A5A5A5,32'hA5A5A5A5,0);
        add(1,0,6'h38,2'b10,0,32'h0,       32'h00000000,0);
        add(1,1,6'h3F,2'b00,1,32'h000000F0,32'hFFFFFFF0,0);
        add(1,0,6'h3C,2'b10,0,32'h0,       32'hF0A5A5A5,0);
        add(1,0,6'h00,2'b10,0,32'h0,       32'h11AABEEF,0);
        add(1,1,6'h0E,2'b01,1,32'h00008001,32'hFFFF8001,0);
        add(1,0,6'h0C,2'b10,0,32'h0,       32'h80015678,0);
        add(1,1,6'h0D,2'b00,0,32'h0000FF22,32'h00000022,0);
        add(1,0,6'h0C,2'b10,0,32'h0,       32'h80012278,0);

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 6'h0, 2'b10, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, bus.busy}, 32'h1);
        check("reset q", bus.q, 32'h0);
        check("reset misalign", {31'b0, bus.misalign}, 32'h0);

        // Hammer the port with a write during the clear; it must be ignored.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 6'h00, 2'b10, 1'b0, 32'hFFFFFFFF);
        count_clear("initial");
        drive(1'b0, 1'b0, 6'h0, 2'b10, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 6'(i * 4), 2'b10, 1'b0, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("cleared word %0d", i), bus.q, 32'h0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].size,
                  vecs[i].sign_ext, vecs[i].d);
            @(posedge clk);
            #1;
            check($sformatf("vec %0d q", i), bus.q, vecs[i].exp_q);
            check($sformatf("vec %0d misalign", i), {31'b0, bus.misalign},
                  {31'b0, vecs[i].exp_mis});
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 6'h0, 2'b10, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset q", bus.q, 32'h0);
        check("async reset busy", {31'b0, bus.busy}, 32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("mid-clear busy", {31'b0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid-clear reset busy", {31'b0, bus.busy}, 32'h1);
        rst_n = 1'b1;
        count_clear("restart");

        read_word("recleared word 15", 6'h3C, 32'h0);
        read_word("recleared word 0", 6'h00, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
